// File: rtl/mbist_repair_cam_pkg.sv
// Shared defaults and entry layout for the MBIST repair CAM.
package mbist_repair_cam_pkg;

    localparam int unsigned DEF_ADDR_WD           = 9;
    localparam int unsigned DEF_RAD_WD_O          = 9;
    localparam int unsigned DEF_REPAIR_ENTRIES    = 4;
    localparam logic [8:0]  DEF_REPAIR_ADDR_START = 9'h1FC;

    typedef struct packed {
        logic                   valid;
        logic [DEF_ADDR_WD-1:0] addr;
    } repair_entry_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mbist_repair_cam_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest asserted bit plus an any flag.
module mbist_repair_cam_prio_enc
    import mbist_repair_cam_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IW'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mbist_repair_cam.sv
// MBIST address-repair CAM: remaps failing logical addresses onto spare words, with scan load/unload.
module mbist_repair_cam
    import mbist_repair_cam_pkg::*;
#(
    parameter  int unsigned              BIST_ADDR_WD           = DEF_ADDR_WD,
    parameter  int unsigned              BIST_RAD_WD_O          = DEF_RAD_WD_O,
    parameter  int unsigned              BIST_REPAIR_ENTRIES    = DEF_REPAIR_ENTRIES,
    parameter  logic [BIST_RAD_WD_O-1:0] BIST_REPAIR_ADDR_START =
        BIST_RAD_WD_O'(DEF_REPAIR_ADDR_START),
    localparam int unsigned              CNT_WD = $clog2(BIST_REPAIR_ENTRIES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [BIST_ADDR_WD-1:0]  AddressIn,
    output logic [BIST_RAD_WD_O-1:0] AddressOut,
    output logic                     repair_hit,
    input  logic                     Error,
    input  logic [BIST_ADDR_WD-1:0]  ErrorAddr,
    output logic                     Correct,
    input  logic                     clear,
    output logic [CNT_WD-1:0]        repair_cnt,
    output logic                     repair_full,
    output logic                     repair_ovf,
    input  logic                     scan_shift,
    input  logic                     sdi,
    output logic                     sdo
);

    localparam int unsigned AW  = BIST_ADDR_WD;
    localparam int unsigned ORW = BIST_RAD_WD_O;
    localparam int unsigned N   = BIST_REPAIR_ENTRIES;
    localparam int unsigned EW  = AW + 1;
    localparam int unsigned IW  = idx_width(N);

    // Entry i occupies bits [i*EW +: EW]; bit AW of each entry is its valid flag.
    logic [N-1:0][EW-1:0] table_q, table_d;
    logic                 correct_q, correct_d;
    logic                 ovf_q, ovf_d;

    logic [N-1:0]  valid_vec;
    logic [N-1:0]  hit_vec;
    logic [N-1:0]  err_match_vec;
    logic [IW-1:0] hit_idx;
    logic [IW-1:0] free_idx;
    logic          free_any;
    logic          err_match;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            valid_vec[i]     = table_q[i][AW];
            hit_vec[i]       = table_q[i][AW] && (table_q[i][AW-1:0] == AddressIn);
            err_match_vec[i] = table_q[i][AW] && (table_q[i][AW-1:0] == ErrorAddr);
        end
    end

    assign err_match = |err_match_vec;

    mbist_repair_cam_prio_enc #(
        .N (N)
    ) u_hit_enc (
        .vec_i (hit_vec),
        .idx_o (hit_idx),
        .any_o (repair_hit)
    );

    mbist_repair_cam_prio_enc #(
        .N (N)
    ) u_free_enc (
        .vec_i (~valid_vec),
        .idx_o (free_idx),
        .any_o (free_any)
    );

    assign AddressOut = repair_hit ? (BIST_REPAIR_ADDR_START + ORW'(hit_idx)) : ORW'(AddressIn);

    always_comb begin
        repair_cnt = '0;
        for (int i = 0; i < int'(N); i++) begin
            repair_cnt = repair_cnt + CNT_WD'(valid_vec[i]);
        end
    end

    assign repair_full = (repair_cnt == CNT_WD'(N));
    assign repair_ovf  = ovf_q;
    assign Correct     = correct_q;
    assign sdo         = table_q[0][0];

    always_comb begin
        table_d   = table_q;
        correct_d = correct_q;
        ovf_d     = ovf_q;
        if (clear) begin
            // Only valid bits drop; stale addresses remain visible to a later scan unload.
            for (int i = 0; i < int'(N); i++) begin
                table_d[i][AW] = 1'b0;
            end
            correct_d = 1'b0;
            ovf_d     = 1'b0;
        end else if (scan_shift) begin
            table_d = {sdi, table_q[N-1:0]} >> 1;
        end else if (Error) begin
            if (err_match) begin
                correct_d = 1'b1;
            end else if (free_any) begin
                table_d[free_idx] = {1'b1, ErrorAddr};
                correct_d         = 1'b1;
            end else begin
                correct_d = 1'b0;
                ovf_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_q   <= '0;
            correct_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            table_q   <= table_d;
            correct_q <= correct_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule
